// File: rtl/conv_layer_seq.sv
// Time-multiplexed 2-D convolution layer: a single MAC walks every tap of every
// output pixel of every filter and streams rescaled, saturated results on a valid/ready port.
module conv_layer_seq #(
  parameter int KSIZE      = 5,
  parameter int IN_SIZE    = 32,
  parameter int IN_CH      = 1,
  parameter int NUM_FILT   = 6,
  parameter int STRIDE     = 1,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int RELU_EN    = 1,
  localparam int OUT_SIZE  = (IN_SIZE - KSIZE) / STRIDE + 1,
  localparam int ACC_W     = 2 * DATA_WIDTH + $clog2(KSIZE * KSIZE * IN_CH),
  localparam int FW        = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1,
  localparam int OW        = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] Image   [IN_CH][IN_SIZE][IN_SIZE],
  input  logic signed [DATA_WIDTH-1:0] Filters [NUM_FILT][IN_CH][KSIZE][KSIZE],
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [FW-1:0]                out_filt,
  output logic [OW-1:0]                out_row,
  output logic [OW-1:0]                out_col,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   dbg_state
);
  // Output handshake: a pixel transfers on a rising edge where out_valid & out_ready;
  // while out_valid is high and out_ready is low every out_* field holds its value.

  localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  localparam logic [KW-1:0] KMAX = KW'(KSIZE - 1);
  localparam logic [CW-1:0] CMAX = CW'(IN_CH - 1);
  localparam logic [OW-1:0] OMAX = OW'(OUT_SIZE - 1);
  localparam logic [FW-1:0] FMAX = FW'(NUM_FILT - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                   state;
  logic [FW-1:0]            filt;
  logic [OW-1:0]            row, col;
  logic [CW-1:0]            ch;
  logic [KW-1:0]            ky, kx;
  logic signed [ACC_W-1:0]  acc;

  logic [IW-1:0]               iy, ix;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]     acc_next, shifted;
  logic [DATA_WIDTH-1:0]       result;
  logic                        last_tap, final_px;

  assign dbg_state = state;

  always_comb begin
    iy       = IW'(int'(row) * STRIDE + int'(ky));
    ix       = IW'(int'(col) * STRIDE + int'(kx));
    prod     = Image[ch][iy][ix] * Filters[filt][ch][ky][kx];
    acc_next = acc + ACC_W'(prod);
    shifted  = acc_next >>> FRAC_BITS;
    if (shifted > SAT_MAX)      result = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    else if (shifted < SAT_MIN) result = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    else                        result = shifted[DATA_WIDTH-1:0];
    if ((RELU_EN != 0) && result[DATA_WIDTH-1]) result = '0;
    last_tap = (kx == KMAX) && (ky == KMAX) && (ch == CMAX);
    final_px = (filt == FMAX) && (row == OMAX) && (col == OMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      filt      <= '0;
      row       <= '0;
      col       <= '0;
      ch        <= '0;
      ky        <= '0;
      kx        <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_filt  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            filt  <= '0;
            row   <= '0;
            col   <= '0;
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          acc   <= '0;
          ch    <= '0;
          ky    <= '0;
          kx    <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_next;
          if (last_tap) begin
            // Final tap folds straight into the rescaled result so EMIT follows immediately.
            out_data  <= result;
            out_filt  <= filt;
            out_row   <= row;
            out_col   <= col;
            out_last  <= final_px;
            out_valid <= 1'b1;
            state     <= EMIT;
          end else if (kx != KMAX) begin
            kx <= kx + 1'b1;
          end else begin
            kx <= '0;
            if (ky != KMAX) begin
              ky <= ky + 1'b1;
            end else begin
              ky <= '0;
              ch <= ch + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= CLEAR;
              if (col != OMAX) begin
                col <= col + 1'b1;
              end else begin
                col <= '0;
                if (row != OMAX) begin
                  row <= row + 1'b1;
                end else begin
                  row  <= '0;
                  filt <= filt + 1'b1;
                end
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: a stride-2 two-channel two-filter instance checked against
// a direct convolution model, plus a small 8-bit ReLU instance checked from a vector table.
module tb_conv_layer_seq;
  // Main instance
  localparam int K  = 2;
  localparam int IN = 8;
  localparam int CH = 2;
  localparam int F  = 2;
  localparam int S  = 2;
  localparam int DW = 16;
  localparam int FB = 4;
  localparam int OS = (IN - K) / S + 1;
  localparam int FW = 1;
  localparam int OW = 2;
  localparam int W  = 1 + FW + 2 * OW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                 start = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] img [CH][IN][IN];
  logic signed [DW-1:0] flt [F][CH][K][K];
  logic [DW-1:0]        out_data;
  logic [FW-1:0]        out_filt;
  logic [OW-1:0]        out_row, out_col;
  logic                 out_valid, out_last, busy, done;
  logic [2:0]           dbg_state;

  // ReLU instance: K=1, 2x2 map, 2 filters, 8-bit, integer
  logic                rstart = 1'b0;
  logic                rready = 1'b1;
  logic signed [7:0]   rimg [1][2][2];
  logic signed [7:0]   rflt [2][1][1][1];
  logic [7:0]          r_data;
  logic [0:0]          r_filt, r_row, r_col;
  logic                r_valid, r_last, r_busy, r_done;
  logic [2:0]          r_state;

  conv_layer_seq #(
    .KSIZE(K), .IN_SIZE(IN), .IN_CH(CH), .NUM_FILT(F), .STRIDE(S),
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .RELU_EN(0)
  ) u_main (
    .clk(clk), .rst(rst), .start(start), .Image(img), .Filters(flt),
    .out_data(out_data), .out_filt(out_filt), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  conv_layer_seq #(
    .KSIZE(1), .IN_SIZE(2), .IN_CH(1), .NUM_FILT(2), .STRIDE(1),
    .DATA_WIDTH(8), .FRAC_BITS(0), .RELU_EN(1)
  ) u_relu (
    .clk(clk), .rst(rst), .start(rstart), .Image(rimg), .Filters(rflt),
    .out_data(r_data), .out_filt(r_filt), .out_row(r_row), .out_col(r_col),
    .out_valid(r_valid), .out_ready(rready), .out_last(r_last),
    .busy(r_busy), .done(r_done), .dbg_state(r_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int stall_pct = 0;
  int n_acc = 0;
  bit mon_en = 1'b0;
  bit prev_stalled = 1'b0;
  bit exp_done_next = 1'b0;
  logic [W-1:0] held;
  logic [W-1:0] exp_q[$];
  wire  [W-1:0] pack_now = {out_last, out_filt, out_row, out_col, out_data};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // consumer back-pressure
  initial forever begin
    @(posedge clk);
    #1 out_ready = (int'($urandom_range(99)) >= stall_pct);
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stalled) check("stall_hold", {out_valid, pack_now}, {1'b1, held});
      if (exp_done_next || done) begin
        check("done_pulse", {63'd0, done}, {63'd0, exp_done_next});
        exp_done_next = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 64'(pack_now), 64'hdead);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("pixel", 64'(pack_now), 64'(e));
          if (e[W-1]) exp_done_next = 1'b1;
          n_acc++;
        end
      end
      prev_stalled = out_valid && !out_ready;
      held = pack_now;
    end
  end

  // direct convolution model with rescale and saturation
  function automatic logic [DW-1:0] model(input int f, input int r, input int c);
    longint sum = 0;
    longint lim = longint'(1) <<< (DW - 1);
    for (int ci = 0; ci < CH; ci++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          sum += longint'(img[ci][r*S+ky][c*S+kx]) * longint'(flt[f][ci][ky][kx]);
    sum = sum >>> FB;
    if (sum > lim - 1) sum = lim - 1;
    if (sum < -lim) sum = -lim;
    return DW'(sum);
  endfunction

  task automatic fill(input int kind);
    for (int ci = 0; ci < CH; ci++)
      for (int y = 0; y < IN; y++)
        for (int x = 0; x < IN; x++)
          case (kind)
            0: img[ci][y][x] = DW'((x + y) * 16);
            1: img[ci][y][x] = DW'(int'($urandom_range(4000)) - 2000);
            2: img[ci][y][x] = DW'(32767);
            default: img[ci][y][x] = DW'(24);
          endcase
    for (int f = 0; f < F; f++)
      for (int ci = 0; ci < CH; ci++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            case (kind)
              0: flt[f][ci][ky][kx] = DW'(16 * (f + 1));
              1: flt[f][ci][ky][kx] = DW'(int'($urandom_range(128)) - 64);
              2: flt[f][ci][ky][kx] = (f == 0) ? DW'(32767) : DW'(-32768);
              default: flt[f][ci][ky][kx] = (f == 0) ? DW'(32) : DW'(-32);
            endcase
  endtask

  task automatic load_and_start(input int kind);
    fill(kind);
    n_acc = 0;
    for (int f = 0; f < F; f++)
      for (int r = 0; r < OS; r++)
        for (int c = 0; c < OS; c++)
          exp_q.push_back({(f == F-1) && (r == OS-1) && (c == OS-1),
                           FW'(f), OW'(r), OW'(c), model(f, r, c)});
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic run_main_pass(input int kind, input int stall);
    bit seen = 1'b0;
    stall_pct = stall;
    load_and_start(kind);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (done) begin
        start = 1'b1;  // must be ignored in DONE
        seen = 1'b1;
        break;
      end
      start = (cyc == 20) || (cyc == 97);
    end
    if (!seen) check("pass_timeout", 64'd0, 64'd1);
    @(negedge clk) start = 1'b0;
    check("idle_after_done", {60'd0, busy, dbg_state}, 64'd0);
    @(negedge clk);
    check("start_in_done_ignored", {60'd0, busy, dbg_state}, 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int kind;
    int stall;
  } main_vec_t;

  typedef struct {
    int img;
    int f0;
    int f1;
    int e0;
    int e1;
  } relu_vec_t;

  task automatic run_relu(input relu_vec_t v);
    int t;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++) rimg[0][y][x] = 8'(v.img);
    rflt[0][0][0][0] = 8'(v.f0);
    rflt[1][0][0][0] = 8'(v.f1);
    @(negedge clk) rstart = 1'b1;
    @(negedge clk) rstart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t = 0;
      while (!r_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!r_valid) begin
        check("relu_timeout", 64'd0, 64'd1);
        return;
      end
      check("relu_px", {51'd0, r_last, r_filt, r_row, r_col, r_data},
            {51'd0, i == 7, 1'(i / 4), 1'((i / 2) % 2), 1'(i % 2), 8'((i < 4) ? v.e0 : v.e1)});
      @(negedge clk);
    end
    t = 0;
    while (!r_done && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("relu_done", {63'd0, r_done}, 64'd1);
    @(negedge clk);
    check("relu_idle", {60'd0, r_busy, r_state}, 64'd0);
  endtask

  main_vec_t main_tab[6];
  relu_vec_t relu_tab[5];

  initial begin
    int t;
    main_tab[0] = '{0, 0};
    main_tab[1] = '{0, 50};
    main_tab[2] = '{1, 30};
    main_tab[3] = '{2, 0};
    main_tab[4] = '{3, 60};
    main_tab[5] = '{1, 0};
    relu_tab[0] = '{127, 127, -127, 127, 0};
    relu_tab[1] = '{5, 3, -3, 15, 0};
    relu_tab[2] = '{-4, 3, -2, 0, 8};
    relu_tab[3] = '{10, 12, -1, 120, 0};
    relu_tab[4] = '{-9, -15, 15, 127, 0};

    fill(0);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++) rimg[0][y][x] = '0;
    rflt[0][0][0][0] = '0;
    rflt[1][0][0][0] = '0;

    repeat (3) @(negedge clk);
    check("reset_main", {40'd0, out_valid, out_last, busy, done, dbg_state, pack_now}, 64'd0);
    check("reset_relu", {47'd0, r_valid, r_last, r_busy, r_done, r_state, r_filt, r_row, r_col, r_data}, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) run_main_pass(main_tab[i].kind, main_tab[i].stall);
    for (int i = 0; i < 5; i++) run_relu(relu_tab[i]);

    // reset in the middle of the fourth pixel's accumulation
    stall_pct = 0;
    load_and_start(1);
    t = 0;
    while ((n_acc < 3 || dbg_state != 3'd2) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reached_mac_px3", {61'd0, dbg_state}, 64'd2);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset", {40'd0, out_valid, out_last, busy, done, dbg_state, pack_now}, 64'd0);
    exp_q.delete();
    prev_stalled = 1'b0;
    exp_done_next = 1'b0;
    @(negedge clk) rst = 1'b0;
    mon_en = 1'b1;
    run_main_pass(1, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
